// File: rtl/lgate_pipe_unit.sv
// Two-stage bitwise logic unit with valid/ready handshake on both sides,
// an optional accumulator feedback path, result flags and a transfer counter.
module lgate_pipe_unit #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [2:0]         in_op,
  input  logic               in_acc,
  input  logic               in_acc_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic               out_zero,
  output logic               out_parity,
  output logic [WIDTH-1:0]   acc_value,
  output logic [COUNT_W-1:0] op_count
);

  logic               s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]   s1_a_q, s1_a_d;
  logic [WIDTH-1:0]   s1_b_q, s1_b_d;
  logic [2:0]         s1_op_q, s1_op_d;
  logic               s1_acc_q, s1_acc_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_result_q, out_result_d;
  logic               out_zero_q, out_zero_d;
  logic               out_parity_q, out_parity_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  logic               s2_free;
  logic               in_fire;
  logic               s1_move;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_res;

  always_comb begin
    s2_free  = !out_valid_q || out_ready;
    in_ready = !s1_valid_q || s2_free;
    in_fire  = in_valid && in_ready;
    s1_move  = s1_valid_q && s2_free;

    // The accumulator is read at the S1->S2 transfer, so back-to-back acc ops chain.
    op_a = s1_acc_q ? acc_q : s1_a_q;
    case (s1_op_q)
      3'd0:    op_res = op_a & s1_b_q;
      3'd1:    op_res = op_a | s1_b_q;
      3'd2:    op_res = op_a ^ s1_b_q;
      3'd3:    op_res = ~(op_a & s1_b_q);
      3'd4:    op_res = ~(op_a | s1_b_q);
      3'd5:    op_res = ~(op_a ^ s1_b_q);
      3'd6:    op_res = ~op_a;
      default: op_res = op_a;
    endcase

    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s1_acc_d   = s1_acc_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_a_d     = in_a;
      s1_b_d     = in_b;
      s1_op_d    = in_op;
      s1_acc_d   = in_acc;
    end else if (s1_move) begin
      s1_valid_d = 1'b0;
    end

    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_zero_d   = out_zero_q;
    out_parity_d = out_parity_q;
    if (s1_move) begin
      out_valid_d  = 1'b1;
      out_result_d = op_res;
      out_zero_d   = (op_res == '0);
      out_parity_d = ^op_res;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // An accumulator write on the same edge takes priority over a clear.
    acc_d = acc_q;
    if (s1_move && s1_acc_q) begin
      acc_d = op_res;
    end else if (in_acc_clr) begin
      acc_d = '0;
    end

    cnt_d = cnt_q;
    if (out_valid_q && out_ready) begin
      cnt_d = cnt_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_op_q      <= 3'd0;
      s1_acc_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_zero_q   <= 1'b1;
      out_parity_q <= 1'b0;
      acc_q        <= '0;
      cnt_q        <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_op_q      <= s1_op_d;
      s1_acc_q     <= s1_acc_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_zero_q   <= out_zero_d;
      out_parity_q <= out_parity_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_zero   = out_zero_q;
  assign out_parity = out_parity_q;
  assign acc_value  = acc_q;
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_lgate_pipe_unit.sv
// Scoreboard bench for lgate_pipe_unit: directed scenarios plus randomized traffic,
// with a second narrow-counter instance sharing the same inputs.
module tb_lgate_pipe_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_acc, in_acc_clr, out_ready;
  logic [7:0]  in_a, in_b;
  logic [2:0]  in_op;

  logic        in_ready, out_valid, out_zero, out_parity;
  logic [7:0]  out_result, acc_value;
  logic [15:0] op_count;

  logic        in_ready_2, out_valid_2, out_zero_2, out_parity_2;
  logic [7:0]  out_result_2, acc_value_2;
  logic [1:0]  op_count_2;

  int          tests = 0;
  int          fails = 0;
  int          xfer_cnt = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  model_acc = 8'h00;
  bit          rand_ready = 1'b0;

  lgate_pipe_unit #(.WIDTH(8), .COUNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .in_acc_clr(in_acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_parity(out_parity), .acc_value(acc_value), .op_count(op_count)
  );

  lgate_pipe_unit #(.WIDTH(8), .COUNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_2),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .in_acc_clr(in_acc_clr),
    .out_valid(out_valid_2), .out_ready(out_ready), .out_result(out_result_2),
    .out_zero(out_zero_2), .out_parity(out_parity_2), .acc_value(acc_value_2),
    .op_count(op_count_2)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_op(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return ~(a ^ b);
      3'd6:    return ~a;
      default: return a;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: counter tracking every cycle, result pop on each output transfer.
  always @(negedge clk) begin
    if (!rst) begin
      check("op_count", 32'(op_count), 32'(xfer_cnt % 65536));
      check("op_count_w2", 32'(op_count_2), 32'(xfer_cnt % 4));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got 0x%0h with empty scoreboard", out_result);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("result", 32'(out_result), 32'(e));
          check("zero_flag", 32'(out_zero), 32'(e == 8'h00));
          check("parity_flag", 32'(out_parity), 32'(^e));
        end
        xfer_cnt++;
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic acc);
    int n = 0;
    logic [7:0] e;
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_acc = acc;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
    end else begin
      e = model_op(op, acc ? model_acc : a, b);
      if (acc) model_acc = e;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic clear_acc();
    in_acc_clr = 1'b1;
    @(posedge clk); #1;
    in_acc_clr = 1'b0;
    model_acc = 8'h00;
    check("acc_clear", 32'(acc_value), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hold;
    rst = 1'b1; in_valid = 1'b0; in_acc = 1'b0; in_acc_clr = 1'b0; out_ready = 1'b1;
    in_a = 8'h00; in_b = 8'h00; in_op = 3'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_out_result", 32'(out_result), 32'h0);
    check("rst_out_zero", 32'(out_zero), 32'h1);
    check("rst_out_parity", 32'(out_parity), 32'h0);
    check("rst_acc", 32'(acc_value), 32'h0);
    check("rst_op_count", 32'(op_count), 32'h0);

    // All eight opcodes streamed back-to-back on fixed operands.
    for (int op = 0; op < 8; op++) begin
      send(3'(op), 8'hCA, 8'h0F, 1'b0);
      if (op == 0) check("latency_not_yet", 32'(out_valid), 32'h0);
      if (op == 1) begin
        check("latency_valid", 32'(out_valid), 32'h1);
        check("latency_and", 32'(out_result), 32'h0A);
      end
    end
    drain();
    check("stream_count", 32'(op_count), 32'd8);

    // Accumulator chain.
    clear_acc();
    send(3'd1, 8'h00, 8'h01, 1'b1);
    send(3'd1, 8'h00, 8'h02, 1'b1);
    send(3'd1, 8'h00, 8'h04, 1'b1);
    drain();
    check("acc_chain", 32'(acc_value), 32'h07);
    send(3'd2, 8'h00, 8'h07, 1'b1);
    drain();
    check("acc_xor_zero", 32'(acc_value), 32'h00);

    // Clear colliding with an accumulator write.
    send(3'd2, 8'h00, 8'h5A, 1'b1);
    drain();
    check("acc_5a", 32'(acc_value), 32'h5A);
    send(3'd0, 8'h00, 8'hFF, 1'b1);
    in_acc_clr = 1'b1;
    @(posedge clk); #1;
    in_acc_clr = 1'b0;
    check("clr_collision", 32'(acc_value), 32'h5A);
    in_acc_clr = 1'b1;
    @(posedge clk); #1;
    in_acc_clr = 1'b0;
    model_acc = 8'h00;
    check("clr_alone", 32'(acc_value), 32'h00);
    drain();

    // Backpressure: two absorbed, third stalled until release.
    out_ready = 1'b0;
    send(3'd2, 8'h11, 8'h22, 1'b0);
    send(3'd3, 8'h33, 8'h44, 1'b0);
    in_valid = 1'b1; in_a = 8'h55; in_b = 8'h66; in_op = 3'd4; in_acc = 1'b0;
    @(negedge clk);
    check("bp_in_ready", 32'(in_ready), 32'h0);
    check("bp_out_valid", 32'(out_valid), 32'h1);
    check("bp_head", 32'(out_result), 32'(exp_q[0]));
    hold = out_result;
    repeat (3) begin
      @(negedge clk);
      check("bp_hold", 32'(out_result), 32'(hold));
      check("bp_stall", 32'(in_ready), 32'h0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(3'd4, 8'h55, 8'h66, 1'b0);
    drain();
    check("bp_count", 32'(op_count), 32'(xfer_cnt));

    // Randomized traffic with random backpressure and accumulator use.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk); #1;
      end
      send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
    end
    rand_ready = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();
    check("rand_acc", 32'(acc_value), 32'(model_acc));

    // Reset with both stages full.
    out_ready = 1'b0;
    send(3'd1, 8'h00, 8'h81, 1'b1);
    send(3'd0, 8'hF0, 8'h3C, 1'b0);
    check("pre_rst_acc", 32'(acc_value), 32'(model_acc));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    xfer_cnt = 0;
    model_acc = 8'h00;
    check("mid_rst_out_valid", 32'(out_valid), 32'h0);
    check("mid_rst_in_ready", 32'(in_ready), 32'h1);
    check("mid_rst_acc", 32'(acc_value), 32'h0);
    check("mid_rst_op_count", 32'(op_count), 32'h0);
    check("mid_rst_zero", 32'(out_zero), 32'h1);
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("no_ghost", 32'(out_valid), 32'h0);
    end
    @(posedge clk); #1;

    // Five transfers wrap the 2-bit counter to 1.
    for (int i = 0; i < 5; i++) send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'b0);
    drain();
    check("wrap_w2", 32'(op_count_2), 32'h1);
    check("wrap_w16", 32'(op_count), 32'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lgate_pipe_unit.md
# lgate_pipe_unit

Parametrised, pipelined successor to the team's two-input gate block: a WIDTH-bit bitwise logic unit with a runtime-selectable operation (AND/OR/XOR/NAND/NOR/XNOR/NOT), a valid/ready handshake on both sides, and an optional accumulator mode that folds the previous result into the next operation. It sits between a stimulus/control front end and downstream result consumers, and supplies zero and parity flags plus a completed-operation counter for lab instrumentation.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (≥1)
- COUNT_W, 16, width of completed-operation counter (≥1)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  unit can accept input this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_op  in  3  operation code (see Operation)
- in_acc  in  1  accumulator mode: use accumulator in place of in_a, write result back
- in_acc_clr  in  1  clear accumulator to 0 (no handshake needed)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  WIDTH  operation result
- out_zero  out  1  out_result == 0
- out_parity  out  1  XOR-reduction of out_result
- acc_value  out  WIDTH  current accumulator contents
- op_count  out  COUNT_W  number of completed output transfers, modulo 2^COUNT_W

## Operation
- Opcodes: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT (result = ~A, B ignored), 7 reserved → result = A (pass-through).
- Operand A = accumulator if the transaction's acc bit is set, else registered in_a.
- Stage 1 (S1): input register; captures in_a, in_b, in_op, in_acc on in_valid && in_ready.
- Stage 2 (S2): computes op on S1 contents, registers out_result/out_zero/out_parity; flags always consistent with out_result.
- Accumulator: updated with the computed result on the same edge S1 transfers to S2, only when that transaction's acc bit = 1. Non-acc transactions never modify it.
- in_acc_clr: accumulator ← 0 on the edge it is sampled high. Same edge as an acc write: the acc write wins (clear is ignored for that cycle). A clear does not affect transactions already past the S1→S2 transfer.
- Handshake: s2_free = !out_valid || out_ready; in_ready = !s1_valid || s2_free (combinational, no registered skid). Inputs must be held stable while in_valid && !in_ready; out_result/flags are held stable while out_valid && !out_ready.
- op_count increments by 1 on every out_valid && out_ready edge; wraps from 2^COUNT_W−1 to 0.
- Reset: s1_valid=0, out_valid=0, out_result=0, out_zero=1, out_parity=0, acc_value=0, op_count=0; in_ready=1 in the first cycle after reset. Reset asserted mid-operation discards all in-flight transactions; no output transfer is generated for them.

## Timing
- Latency: input accepted at edge N → out_valid high after edge N+1 (2-register pipeline, result visible in cycle N+2 relative to accept cycle N).
- Throughput: one transaction per cycle while out_ready = 1.
- Back-to-back accumulator ops: each sees the accumulator as written by the immediately preceding acc op; no bubbles required.
- Backpressure: with out_ready = 0 the pipe absorbs exactly 2 transactions (S1 + S2), then in_ready = 0 until out_ready returns.
- Simultaneous out_ready and new input when full: S2 drains, S1 advances, and the new input is captured on the same edge.

## Test plan
- Reset then WIDTH=8, a=0xCA, b=0x0F, ops 0..7 streamed back-to-back, out_ready=1 → results 0x0A, 0xCF, 0xC5, 0xF5, 0x30, 0x3A, 0x35, 0xCA on 8 consecutive cycles starting 2 cycles after the first accept; op_count=8.
- Accumulator: clear, then in_acc=1 op OR with b=0x01, 0x02, 0x04 back-to-back → results 0x01, 0x03, 0x07; acc_value=0x07; then op XOR b=0x07 acc → result 0x00, out_zero=1, out_parity=0.
- Backpressure: out_ready=0, offer 3 inputs → first 2 accepted, in_ready=0 on the third; out_result held stable; release out_ready → all 3 delivered in order with no loss or duplication.
- Clear collision: acc op AND b=0xFF with acc=0x5A while in_acc_clr=1 on the transfer edge → acc_value=0x5A afterwards; next cycle clear alone → acc_value=0x00.
- Counter wrap with COUNT_W=2: 5 transfers → op_count sequence 1,2,3,0,1.
- Reset mid-stream: assert rst with S1 and S2 both full → next cycle out_valid=0, in_ready=1, acc_value=0, op_count=0, out_zero=1; no transfer of the discarded data.
